// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: operand capture, B-operand select,
// load-use bubble insertion and EX/MEM, MEM/WB forwarding (enabled by `define ID_EX_FWD_EN).
module id_ex_operand_stage #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_id_valid,
    input  logic [3:0]              i_ALU_Ctrl,
    input  logic [WORD_LEN-1:0]     i_rs_data,
    input  logic [WORD_LEN-1:0]     i_rt_data,
    input  logic [WORD_LEN-1:0]     i_imm,
    input  logic                    i_alu_src,
    input  logic [REG_ADDR_LEN-1:0] i_rs_addr,
    input  logic [REG_ADDR_LEN-1:0] i_rt_addr,
    input  logic [REG_ADDR_LEN-1:0] i_rd_addr,
    input  logic                    i_reg_write,
    input  logic                    i_mem_read,
    input  logic                    i_exmem_reg_write,
    input  logic [REG_ADDR_LEN-1:0] i_exmem_rd,
    input  logic [WORD_LEN-1:0]     i_exmem_data,
    input  logic                    i_memwb_reg_write,
    input  logic [REG_ADDR_LEN-1:0] i_memwb_rd,
    input  logic [WORD_LEN-1:0]     i_memwb_data,
    output logic                    o_valid,
    output logic [3:0]              o_ALU_Ctrl,
    output logic [WORD_LEN-1:0]     o_A,
    output logic [WORD_LEN-1:0]     o_B,
    output logic [WORD_LEN-1:0]     o_store_data,
    output logic [REG_ADDR_LEN-1:0] o_rd_addr,
    output logic                    o_reg_write,
    output logic                    o_mem_read,
    output logic                    o_load_use
);

    logic                    vld_p1;
    logic [3:0]              alu_ctrl_p1;
    logic [WORD_LEN-1:0]     rs_data_p1;
    logic [WORD_LEN-1:0]     rt_data_p1;
    logic [WORD_LEN-1:0]     imm_p1;
    logic                    alu_src_p1;
    logic [REG_ADDR_LEN-1:0] rs_addr_p1;
    logic [REG_ADDR_LEN-1:0] rt_addr_p1;
    logic [REG_ADDR_LEN-1:0] rd_addr_p1;
    logic                    reg_write_p1;
    logic                    mem_read_p1;

    logic                    load_use;
    logic [WORD_LEN-1:0]     fwd_rs;
    logic [WORD_LEN-1:0]     fwd_rt;

    // A load in EX whose destination is read by the instruction in ID must wait one cycle.
    assign load_use = vld_p1 && mem_read_p1 && (rd_addr_p1 != '0) &&
                      ((rd_addr_p1 == i_rs_addr) || (rd_addr_p1 == i_rt_addr));

    // ID -> EX stage boundary
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || i_flush || (!i_stall && load_use)) begin
            vld_p1       <= 1'b0;
            alu_ctrl_p1  <= '0;
            rs_data_p1   <= '0;
            rt_data_p1   <= '0;
            imm_p1       <= '0;
            alu_src_p1   <= 1'b0;
            rs_addr_p1   <= '0;
            rt_addr_p1   <= '0;
            rd_addr_p1   <= '0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
        end else if (!i_stall) begin
            vld_p1       <= i_id_valid;
            alu_ctrl_p1  <= i_ALU_Ctrl;
            rs_data_p1   <= i_rs_data;
            rt_data_p1   <= i_rt_data;
            imm_p1       <= i_imm;
            alu_src_p1   <= i_alu_src;
            rs_addr_p1   <= i_rs_addr;
            rt_addr_p1   <= i_rt_addr;
            rd_addr_p1   <= i_rd_addr;
            reg_write_p1 <= i_reg_write & i_id_valid;
            mem_read_p1  <= i_mem_read & i_id_valid;
        end
    end

`ifdef ID_EX_FWD_EN
    // Youngest producer wins; register 0 is hard-wired and never forwarded.
    function automatic logic [WORD_LEN-1:0] fwd_sel(
        input logic [REG_ADDR_LEN-1:0] idx,
        input logic [WORD_LEN-1:0]     rf_data,
        input logic                    exmem_we,
        input logic [REG_ADDR_LEN-1:0] exmem_rd,
        input logic [WORD_LEN-1:0]     exmem_data,
        input logic                    memwb_we,
        input logic [REG_ADDR_LEN-1:0] memwb_rd,
        input logic [WORD_LEN-1:0]     memwb_data
    );
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == idx))
            return exmem_data;
        else if (memwb_we && (memwb_rd != '0) && (memwb_rd == idx))
            return memwb_data;
        else
            return rf_data;
    endfunction

    assign fwd_rs = fwd_sel(rs_addr_p1, rs_data_p1, i_exmem_reg_write, i_exmem_rd,
                            i_exmem_data, i_memwb_reg_write, i_memwb_rd, i_memwb_data);
    assign fwd_rt = fwd_sel(rt_addr_p1, rt_data_p1, i_exmem_reg_write, i_exmem_rd,
                            i_exmem_data, i_memwb_reg_write, i_memwb_rd, i_memwb_data);
`else
    logic unused_fwd;

    assign unused_fwd = ^{i_exmem_reg_write, i_exmem_rd, i_exmem_data,
                          i_memwb_reg_write, i_memwb_rd, i_memwb_data,
                          rs_addr_p1, rt_addr_p1};
    assign fwd_rs = rs_data_p1;
    assign fwd_rt = rt_data_p1;
`endif

    assign o_valid      = vld_p1;
    assign o_ALU_Ctrl   = alu_ctrl_p1;
    assign o_A          = fwd_rs;
    assign o_B          = alu_src_p1 ? imm_p1 : fwd_rt;
    assign o_store_data = fwd_rt;
    assign o_rd_addr    = rd_addr_p1;
    assign o_reg_write  = reg_write_p1;
    assign o_mem_read   = mem_read_p1;
    assign o_load_use   = load_use;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register in front of the ALU.
- Captures decoded ALU control, register operands and immediate; selects the immediate or forwarded rt as operand B; drives the ALU inputs A, B and ALU_Ctrl.
- Resolves EX/MEM and MEM/WB data hazards by forwarding.
- Detects load-use hazards and inserts bubbles.

Parameters:
- WORD_LEN, 32, datapath width of operands and results
- REG_ADDR_LEN, 5, register-file address width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold all stage registers
- i_flush  in  1  replace stage contents with a bubble
- i_id_valid  in  1  ID stage holds a real instruction
- i_ALU_Ctrl  in  4  decoded ALU operation
- i_rs_data  in  WORD_LEN  register-file read data, rs
- i_rt_data  in  WORD_LEN  register-file read data, rt
- i_imm  in  WORD_LEN  extended immediate; shamt in bits [10:6]
- i_alu_src  in  1  1: B = immediate, 0: B = rt
- i_rs_addr  in  REG_ADDR_LEN  rs index
- i_rt_addr  in  REG_ADDR_LEN  rt index
- i_rd_addr  in  REG_ADDR_LEN  destination index
- i_reg_write  in  1  instruction writes rd
- i_mem_read  in  1  instruction is a load
- i_exmem_reg_write  in  1  EX/MEM writes back
- i_exmem_rd  in  REG_ADDR_LEN  EX/MEM destination
- i_exmem_data  in  WORD_LEN  EX/MEM ALU result
- i_memwb_reg_write  in  1  MEM/WB writes back
- i_memwb_rd  in  REG_ADDR_LEN  MEM/WB destination
- i_memwb_data  in  WORD_LEN  MEM/WB write-back value
- o_valid  out  1  EX holds a real instruction
- o_ALU_Ctrl  out  4  to ALU
- o_A  out  WORD_LEN  to ALU operand A
- o_B  out  WORD_LEN  to ALU operand B
- o_store_data  out  WORD_LEN  forwarded rt for stores
- o_rd_addr  out  REG_ADDR_LEN  registered destination
- o_reg_write  out  1  registered write enable; 0 when o_valid is 0
- o_mem_read  out  1  registered load flag; 0 when o_valid is 0
- o_load_use  out  1  stall request to PC/IF/ID

Behaviour:
- Reset (i_rst_n low, asynchronous): every stage register is cleared to 0. Outputs therefore read 0: o_valid, o_ALU_Ctrl, o_rd_addr, o_reg_write, o_mem_read, o_A, o_B, o_store_data, o_load_use. Reset asserted mid-stall also clears the stage.
- Capture priority per rising edge, highest first:
  1. i_flush → bubble.
  2. i_stall → hold all registers.
  3. o_load_use → bubble.
  4. Otherwise capture ID inputs; o_valid <= i_id_valid.
- Bubble: o_valid = 0, o_reg_write = 0, o_mem_read = 0, o_rd_addr = 0, o_ALU_Ctrl = 0. Data registers are don't-care but held at 0.
- Latency: ID values appear on outputs 1 cycle after capture.
- o_load_use (combinational): o_valid & o_mem_read & (o_rd_addr != 0) & ((o_rd_addr == i_rs_addr) | (o_rd_addr == i_rt_addr)). Produces exactly one bubble per load-use pair.
- Forwarding (combinational on the registered rs/rt values, per operand):
  - Select EX/MEM data if i_exmem_reg_write & i_exmem_rd != 0 & i_exmem_rd == the registered index.
  - Otherwise select MEM/WB data under the same rule using i_memwb_*.
  - Otherwise use the registered register-file data.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- Operand outputs:
  - o_A = forwarded rs.
  - o_store_data = forwarded rt.
  - o_B = registered immediate if the registered alu_src is 1, else forwarded rt.
- The stage never performs arithmetic; all widths pass through unchanged.

Optional Feature:
- ID_EX_FWD_EN defined: forwarding muxes present as described above.
- ID_EX_FWD_EN undefined:
  - All i_exmem_* and i_memwb_* inputs are ignored.
  - o_A and o_store_data = registered register-file data; o_B = immediate or registered rt.
  - o_load_use logic is unchanged.

Test Plan:
- Reset: hold i_rst_n = 0 mid-stream → all outputs 0 immediately, without waiting for a clock edge.
- Capture: i_id_valid = 1, i_ALU_Ctrl = ADD, i_rs_data = 5, i_rt_data = 7, i_alu_src = 0 → next cycle o_A = 5, o_B = 7, o_valid = 1.
- Forwarding priority: registered rs = 3; i_exmem_rd = 3 with data 0xAA; i_memwb_rd = 3 with data 0xBB; both write enables 1 → o_A = 0xAA. Drop i_exmem_reg_write → o_A = 0xBB. Use rd = 0 → no forward.
- Immediate path: i_alu_src = 1, i_imm = 0x0000_0140 (shamt 5) with rt forwarding active → o_B = 0x140, o_store_data = forwarded value.
- Load-use: load to r4 in EX while ID has rs = 4 → o_load_use = 1, next cycle o_valid = 0 and o_load_use = 0. ID held by upstream is captured on the following edge.
- Stall vs flush: i_stall = 1 for 3 cycles → outputs constant. i_stall = 1 and i_flush = 1 together → bubble captured.
